// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg -- shared types and constants for the RV pipeline slice.
//   XLEN      default datapath width
//   REG_X0    architectural zero register index
//   fwd_sel_e operand source chosen by operand_fwd
package rv_pipe_pkg;

   localparam int XLEN = 32;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

endpackage

// File: rtl/operand_fwd.sv
// operand_fwd -- combinational forwarding mux for one source operand.
// Priority: EX > MEM > WB > reg_file. x0 always resolves to zero.
// Macro RF_WB_BYPASS_EN: when defined the WB path forwards wb_data; when
// undefined a WB-only match raises wb_stall instead.
// Ports:
//   rs                  source register index
//   rf_data             reg_file read data for rs
//   ex_en/ex_rd/ex_data EX-stage forward candidate (ex_en already excludes loads)
//   mem_en/mem_rd/mem_data  MEM-stage forward candidate
//   wb_en/wb_rd/wb_data     WB-stage forward candidate
//   value               resolved operand
//   sel                 which source was chosen
//   wb_stall            WB-only match with the WB path removed
module operand_fwd
   import rv_pipe_pkg::*;
#(
   parameter int XLEN = rv_pipe_pkg::XLEN
) (
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] rf_data,
   input  logic            ex_en,
   input  logic [4:0]      ex_rd,
   input  logic [XLEN-1:0] ex_data,
   input  logic            mem_en,
   input  logic [4:0]      mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] value,
   output fwd_sel_e        sel,
   output logic            wb_stall
);

   logic ex_hit, mem_hit, wb_hit;

   assign ex_hit  = ex_en  & (ex_rd  == rs);
   assign mem_hit = mem_en & (mem_rd == rs);
   assign wb_hit  = wb_en  & (wb_rd  == rs);

   always_comb begin
      value    = rf_data;
      sel      = FWD_RF;
      wb_stall = 1'b0;
      if (rs == REG_X0) begin
         value = '0;
      end else if (ex_hit) begin
         value = ex_data;
         sel   = FWD_EX;
      end else if (mem_hit) begin
         value = mem_data;
         sel   = FWD_MEM;
`ifdef RF_WB_BYPASS_EN
      end else if (wb_hit) begin
         value = wb_data;
         sel   = FWD_WB;
      end
`else
      end else if (wb_hit) begin
         // reg_file has not absorbed the write yet; wait one cycle for it
         wb_stall = 1'b1;
      end
`endif
   end

`ifndef RF_WB_BYPASS_EN
   logic wb_data_unused;
   assign wb_data_unused = ^wb_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with operand forwarding and
// load-use / WB hazard handling.
// Macro RF_WB_BYPASS_EN: enables the WB forward path; when undefined a
// WB-only source match stalls for one cycle like a load-use.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_*                       decoded ID instruction bundle
//   rf_rdata1/2                reg_file read data for id_rs1/id_rs2
//   ex_result                  combinational result of the EX instruction
//   mem_rd/mem_rf_en/mem_wdata MEM writeback candidate
//   wb_rd/wb_rf_en/wb_wdata    WB writeback (same as reg_file write port)
//   flush                      kill the ID instruction
//   hold                       downstream busy, freeze EX
//   stall                      hold IF/ID this cycle
//   ex_*                       registered bundle presented to EX
module id_ex_stage
   import rv_pipe_pkg::*;
#(
   parameter int XLEN   = rv_pipe_pkg::XLEN,
   parameter int CTRL_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [4:0]        id_rd,
   input  logic              id_rf_en,
   input  logic              id_is_load,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   input  logic [XLEN-1:0]   ex_result,
   input  logic [4:0]        mem_rd,
   input  logic              mem_rf_en,
   input  logic [XLEN-1:0]   mem_wdata,
   input  logic [4:0]        wb_rd,
   input  logic              wb_rf_en,
   input  logic [XLEN-1:0]   wb_wdata,
   input  logic              flush,
   input  logic              hold,
   output logic              stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_imm,
   output logic [XLEN-1:0]   ex_opa,
   output logic [XLEN-1:0]   ex_opb,
   output logic [4:0]        ex_rd,
   output logic              ex_rf_en,
   output logic              ex_is_load,
   output logic [CTRL_W-1:0] ex_ctrl
);

   logic [XLEN-1:0] opa, opb;
   fwd_sel_e        sel1_unused, sel2_unused;  // kept for debug visibility
   logic            wbs1, wbs2;
   logic            ex_fwd_en, lu, wb_haz, bubble;

   // A load's ex_result is its address, not its data, so EX never forwards it.
   assign ex_fwd_en = ex_valid & ex_rf_en & ~ex_is_load;

   operand_fwd #(.XLEN(XLEN)) u_fwd_rs1 (
      .rs(id_rs1), .rf_data(rf_rdata1),
      .ex_en(ex_fwd_en), .ex_rd(ex_rd), .ex_data(ex_result),
      .mem_en(mem_rf_en), .mem_rd(mem_rd), .mem_data(mem_wdata),
      .wb_en(wb_rf_en), .wb_rd(wb_rd), .wb_data(wb_wdata),
      .value(opa), .sel(sel1_unused), .wb_stall(wbs1)
   );

   operand_fwd #(.XLEN(XLEN)) u_fwd_rs2 (
      .rs(id_rs2), .rf_data(rf_rdata2),
      .ex_en(ex_fwd_en), .ex_rd(ex_rd), .ex_data(ex_result),
      .mem_en(mem_rf_en), .mem_rd(mem_rd), .mem_data(mem_wdata),
      .wb_en(wb_rf_en), .wb_rd(wb_rd), .wb_data(wb_wdata),
      .value(opb), .sel(sel2_unused), .wb_stall(wbs2)
   );

   assign lu = id_valid & ex_valid & ex_is_load & (ex_rd != REG_X0) &
               ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   // Always zero when the WB forward path is present.
   assign wb_haz = id_valid & ((id_use_rs1 & wbs1) | (id_use_rs2 & wbs2));

   assign bubble = lu | wb_haz;

   // Gated by rst_n so stall drops the moment reset asserts.
   assign stall = rst_n & ~flush & (hold | bubble);

   // ID -> EX boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_rf_en   <= 1'b0;
         ex_is_load <= 1'b0;
         ex_pc      <= '0;
         ex_imm     <= '0;
         ex_opa     <= '0;
         ex_opb     <= '0;
         ex_rd      <= '0;
         ex_ctrl    <= '0;
      end else if (flush) begin
         ex_valid   <= 1'b0;
         ex_rf_en   <= 1'b0;
         ex_is_load <= 1'b0;
      end else if (hold) begin
         ex_valid   <= ex_valid;
      end else if (bubble) begin
         ex_valid   <= 1'b0;
         ex_rf_en   <= 1'b0;
         ex_is_load <= 1'b0;
      end else begin
         ex_valid   <= id_valid;
         ex_rf_en   <= id_rf_en & id_valid;
         ex_is_load <= id_is_load & id_valid;
         ex_pc      <= id_pc;
         ex_imm     <= id_imm;
         ex_opa     <= opa;
         ex_opb     <= opb;
         ex_rd      <= id_rd;
         ex_ctrl    <= id_ctrl;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage -- directed self-checking bench for id_ex_stage.
// Honours RF_WB_BYPASS_EN the same way as the design.
module tb_id_ex_stage;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 16;

   logic              clk, rst_n;
   logic              id_valid, id_use_rs1, id_use_rs2, id_rf_en, id_is_load;
   logic [XLEN-1:0]   id_pc, id_imm, rf_rdata1, rf_rdata2, ex_result, mem_wdata, wb_wdata;
   logic [4:0]        id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
   logic [CTRL_W-1:0] id_ctrl;
   logic              mem_rf_en, wb_rf_en, flush, hold;
   logic              stall, ex_valid, ex_rf_en, ex_is_load;
   logic [XLEN-1:0]   ex_pc, ex_imm, ex_opa, ex_opb;
   logic [4:0]        ex_rd;
   logic [CTRL_W-1:0] ex_ctrl;

   int vec  = 0;
   int errs = 0;

   id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_rf_en(id_rf_en), .id_is_load(id_is_load), .id_imm(id_imm), .id_ctrl(id_ctrl),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_rf_en(mem_rf_en), .mem_wdata(mem_wdata),
      .wb_rd(wb_rd), .wb_rf_en(wb_rf_en), .wb_wdata(wb_wdata),
      .flush(flush), .hold(hold), .stall(stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_opa(ex_opa),
      .ex_opb(ex_opb), .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_is_load(ex_is_load),
      .ex_ctrl(ex_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
      id_rd = '0; id_rf_en = 0; id_is_load = 0; id_imm = '0; id_ctrl = '0;
      rf_rdata1 = '0; rf_rdata2 = '0; ex_result = '0;
      mem_rd = '0; mem_rf_en = 0; mem_wdata = '0;
      wb_rd = '0; wb_rf_en = 0; wb_wdata = '0;
      flush = 0; hold = 0;
   endtask

   task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic rfe, input logic ld, input logic [31:0] imm);
      id_valid = 1; id_pc = pc; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
      id_use_rs2 = u2; id_rd = rd; id_rf_en = rfe; id_is_load = ld; id_imm = imm;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle();
      hold = 1;
      set_id(32'h40, 5'd1, 1, 5'd0, 0, 5'd2, 1, 0, 32'h0);
      tick(); tick();
      vec++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", ex_valid); end
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b want 0", stall); end
      vec++; if (ex_pc !== 32'h0 || ex_rf_en !== 1'b0 || ex_is_load !== 1'b0)
         begin errs++; $display("FAIL rst_fields: got pc=%h rf_en=%b ld=%b want 0", ex_pc, ex_rf_en, ex_is_load); end
      hold = 0;
      rst_n = 1;
      set_id(32'h100, 5'd1, 1, 5'd0, 0, 5'd2, 1, 0, 32'h0);
      rf_rdata1 = 32'h77;
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_opa !== 32'h77)
         begin errs++; $display("FAIL rst_first_capture: got v=%b pc=%h opa=%h want 1 100 77", ex_valid, ex_pc, ex_opa); end
      hold = 1;
      #1;
      vec++; if (stall !== 1'b1) begin errs++; $display("FAIL hold_stall_pre_rst: got %b want 1", stall); end
      rst_n = 0;
      #1;
      vec++; if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_pc !== 32'h0)
         begin errs++; $display("FAIL rst_mid_stall: got stall=%b v=%b pc=%h want 0 0 0", stall, ex_valid, ex_pc); end
      rst_n = 1;
      hold = 0;
      set_id(32'h200, 5'd0, 0, 5'd0, 0, 5'd4, 1, 0, 32'h8);
      id_ctrl = 16'hC0DE;
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_ctrl !== 16'hC0DE || ex_imm !== 32'h8)
         begin errs++; $display("FAIL post_rst_capture: got v=%b pc=%h ctrl=%h imm=%h", ex_valid, ex_pc, ex_ctrl, ex_imm); end
   endtask

   task automatic test_ex_mem_priority();
      idle();
      set_id(32'h300, 5'd0, 0, 5'd0, 0, 5'd5, 1, 0, 32'h0);
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_rf_en !== 1'b1)
         begin errs++; $display("FAIL prod_x5: got v=%b rd=%0d rfe=%b want 1 5 1", ex_valid, ex_rd, ex_rf_en); end
      ex_result = 32'h11; mem_rd = 5'd5; mem_rf_en = 1; mem_wdata = 32'h22; rf_rdata1 = 32'h99;
      set_id(32'h304, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 32'h1);
      #1;
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL prio_stall: got %b want 0", stall); end
      tick();
      vec++; if (ex_opa !== 32'h11 || ex_imm !== 32'h1 || ex_rd !== 5'd6)
         begin errs++; $display("FAIL ex_over_mem: got opa=%h imm=%h rd=%0d want 11 1 6", ex_opa, ex_imm, ex_rd); end
      ex_result = 32'h66; rf_rdata2 = 32'h98;
      set_id(32'h308, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 32'h0);
      tick();
      vec++; if (ex_opa !== 32'h22) begin errs++; $display("FAIL mem_fwd_rs1: got %h want 22", ex_opa); end
      vec++; if (ex_opb !== 32'h66) begin errs++; $display("FAIL ex_fwd_rs2: got %h want 66", ex_opb); end
   endtask

   task automatic test_load_use();
      idle();
      rf_rdata1 = 32'h1000;
      set_id(32'h400, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 32'h8);
      tick();
      vec++; if (ex_is_load !== 1'b1 || ex_valid !== 1'b1)
         begin errs++; $display("FAIL lw_in_ex: got ld=%b v=%b want 1 1", ex_is_load, ex_valid); end
      idle();
      ex_result = 32'h1008; rf_rdata1 = 32'h0; rf_rdata2 = 32'h10;
      set_id(32'h404, 5'd5, 1, 5'd1, 1, 5'd7, 1, 0, 32'h0);
      #1;
      vec++; if (stall !== 1'b1) begin errs++; $display("FAIL lu_stall: got %b want 1", stall); end
      tick();
      vec++; if (ex_valid !== 1'b0 || ex_rf_en !== 1'b0)
         begin errs++; $display("FAIL lu_bubble: got v=%b rfe=%b want 0 0", ex_valid, ex_rf_en); end
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL lu_one_cycle: got %b want 0", stall); end
      ex_result = 32'h0; mem_rd = 5'd5; mem_rf_en = 1; mem_wdata = 32'hDEAD;
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_opa !== 32'hDEAD || ex_opb !== 32'h10 || ex_pc !== 32'h404)
         begin errs++; $display("FAIL lu_mem_fwd: got v=%b opa=%h opb=%h pc=%h want 1 dead 10 404", ex_valid, ex_opa, ex_opb, ex_pc); end
   endtask

   task automatic test_x0_unused();
      idle();
      mem_rd = 5'd0; mem_rf_en = 1; mem_wdata = 32'h55;
      set_id(32'h500, 5'd0, 1, 5'd0, 0, 5'd5, 1, 1, 32'h0);
      tick();
      vec++; if (ex_opa !== 32'h0 || ex_is_load !== 1'b1 || ex_valid !== 1'b1)
         begin errs++; $display("FAIL x0_no_fwd: got opa=%h ld=%b v=%b want 0 1 1", ex_opa, ex_is_load, ex_valid); end
      idle();
      rf_rdata1 = 32'h31;
      set_id(32'h504, 5'd1, 1, 5'd5, 0, 5'd8, 1, 0, 32'h0);
      #1;
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL unused_rs2_stall: got %b want 0", stall); end
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_opa !== 32'h31)
         begin errs++; $display("FAIL unused_rs2_capture: got v=%b opa=%h want 1 31", ex_valid, ex_opa); end
   endtask

   task automatic test_wb_bypass();
      idle();
      wb_rd = 5'd3; wb_rf_en = 1; wb_wdata = 32'hABCD; rf_rdata1 = 32'h0;
      set_id(32'h600, 5'd3, 1, 5'd0, 0, 5'd9, 1, 0, 32'h0);
      #1;
`ifdef RF_WB_BYPASS_EN
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL wb_byp_stall: got %b want 0", stall); end
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_opa !== 32'hABCD)
         begin errs++; $display("FAIL wb_byp_opa: got v=%b opa=%h want 1 abcd", ex_valid, ex_opa); end
`else
      vec++; if (stall !== 1'b1) begin errs++; $display("FAIL wb_nobyp_stall: got %b want 1", stall); end
      tick();
      vec++; if (ex_valid !== 1'b0) begin errs++; $display("FAIL wb_nobyp_bubble: got %b want 0", ex_valid); end
      wb_rf_en = 0; rf_rdata1 = 32'hABCD;
      #1;
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL wb_nobyp_release: got %b want 0", stall); end
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_opa !== 32'hABCD)
         begin errs++; $display("FAIL wb_nobyp_opa: got v=%b opa=%h want 1 abcd", ex_valid, ex_opa); end
`endif
   endtask

   task automatic test_flush_hold();
      idle();
      set_id(32'h700, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 32'h0);
      tick();
      set_id(32'h704, 5'd5, 1, 5'd0, 0, 5'd10, 1, 0, 32'h0);
      hold = 1; flush = 1;
      #1;
      vec++; if (stall !== 1'b0) begin errs++; $display("FAIL flush_release: got %b want 0", stall); end
      tick();
      vec++; if (ex_valid !== 1'b0 || ex_rf_en !== 1'b0)
         begin errs++; $display("FAIL flush_kill: got v=%b rfe=%b want 0 0", ex_valid, ex_rf_en); end
      flush = 0; hold = 0;
      set_id(32'h708, 5'd0, 0, 5'd0, 0, 5'd5, 1, 1, 32'h4);
      id_ctrl = 16'hBEEF;
      tick();
      vec++; if (ex_valid !== 1'b1 || ex_pc !== 32'h708)
         begin errs++; $display("FAIL pre_hold_capture: got v=%b pc=%h want 1 708", ex_valid, ex_pc); end
      hold = 1;
      set_id(32'h70C, 5'd0, 0, 5'd0, 0, 5'd11, 1, 0, 32'hFFFF);
      id_ctrl = 16'h0;
      #1;
      vec++; if (stall !== 1'b1) begin errs++; $display("FAIL hold_stall: got %b want 1", stall); end
      tick();
      vec++; if (ex_pc !== 32'h708 || ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_is_load !== 1'b1 ||
                 ex_imm !== 32'h4 || ex_ctrl !== 16'hBEEF || ex_rf_en !== 1'b1)
         begin errs++; $display("FAIL hold_freeze: got pc=%h v=%b rd=%0d ld=%b imm=%h ctrl=%h", ex_pc, ex_valid, ex_rd, ex_is_load, ex_imm, ex_ctrl); end
      hold = 0;
      tick();
      vec++; if (ex_pc !== 32'h70C || ex_rd !== 5'd11 || ex_is_load !== 1'b0 || ex_imm !== 32'hFFFF)
         begin errs++; $display("FAIL post_hold_capture: got pc=%h rd=%0d ld=%b imm=%h want 70c 11 0 ffff", ex_pc, ex_rd, ex_is_load, ex_imm); end
   endtask

   initial begin
      rst_n = 0;
      idle();
      test_reset();
      test_ex_mem_priority();
      test_load_use();
      test_x0_unused();
      test_wb_bypass();
      test_flush_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
